// File: rtl/ber_stream_monitor.sv
// ber_stream_monitor
// Aligns the generator (TX) word stream with the decoder (RX) word stream
// through a reference FIFO, compares them word by word and counts TX words,
// RX words, channel error strobes and post-decode bit errors. After
// FRAME_WORDS compares it reports a pass/fail verdict against ERR_LIMIT.
// Optional build macro: BER_FIRST_ERR_CAPTURE_EN captures the 0-based index
// of the first mismatching RX word; without it first_err_* are tied to 0.
module ber_stream_monitor #(
    parameter int DATA_W      = 1,
    parameter int DEPTH       = 64,
    parameter int CNT_W       = 32,
    parameter int FRAME_WORDS = 200,
    parameter int ERR_LIMIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              chan_err_valid,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  chan_err_count,
    output logic [CNT_W-1:0]  bit_err_count,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fault,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              first_err_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full;
    logic              do_clear, run_ok, do_push, do_pop, do_cmp;
    logic [DATA_W-1:0] ref_word, diff;
    logic [PW-1:0]     err_bits;

    // Saturating add: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // The extra wrap bit tells a full FIFO from an empty one with equal indices.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // An empty FIFO with a same-cycle TX word compares RX straight against it.
    assign ref_word = fifo_empty ? tx_data : mem[rd_ptr[AW-1:0]];
    assign diff     = ref_word ^ rx_data;

    // Number of mismatching bits in the current compare.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see the
        // updated value; clocked blocks use '<=' so all registers update together.
        err_bits = '0;
        for (int i = 0; i < DATA_W; i++) begin
            err_bits = err_bits + PW'(diff[i]);
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        do_clear = 1'b0;
        run_ok   = 1'b0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_cmp   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) begin
                    state_d  = S_RUN;
                    do_clear = 1'b1;
                end
            end
            S_RUN: begin
                if ((tx_valid && !rx_valid && fifo_full) ||
                    (rx_valid && !tx_valid && fifo_empty)) begin
                    state_d = S_FAULT;
                end else begin
                    run_ok  = 1'b1;
                    do_cmp  = rx_valid;
                    do_push = tx_valid && !(rx_valid && fifo_empty);
                    do_pop  = rx_valid && !fifo_empty;
                    if (rx_valid && (rx_count == CNT_W'(FRAME_WORDS - 1))) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign fault = (state_q == S_FAULT);
    assign pass  = done && (bit_err_count <= CNT_W'(ERR_LIMIT));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO pointers; START empties the FIFO by realigning them.
    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; validity is carried entirely by
        // the pointers, and leaving it unreset lets it map onto plain RAM.
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    // Word, strobe and bit-error counters; frozen outside a healthy RUN cycle.
    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            tx_count       <= '0;
            rx_count       <= '0;
            chan_err_count <= '0;
            bit_err_count  <= '0;
        end else if (run_ok) begin
            if (tx_valid)       tx_count       <= sat_add(tx_count, CNT_W'(1));
            if (chan_err_valid) chan_err_count <= sat_add(chan_err_count, CNT_W'(1));
            if (do_cmp) begin
                rx_count      <= sat_add(rx_count, CNT_W'(1));
                bit_err_count <= sat_add(bit_err_count, CNT_W'(err_bits));
            end
        end
    end

`ifdef BER_FIRST_ERR_CAPTURE_EN
    // Latch the 0-based RX index of the first compare with any mismatch.
    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else if (do_cmp && (err_bits != '0) && !first_err_valid) begin
            first_err_idx   <= rx_count;
            first_err_valid <= 1'b1;
        end
    end
`else
    assign first_err_idx   = '0;
    assign first_err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ber_stream_monitor.sv
// Self-checking bench for ber_stream_monitor. Instance A uses the default
// parameters (1-bit words, 64-deep FIFO, 200-word frame); instance B uses
// 4-bit words, a 4-deep FIFO and an 8-word frame for the width and FIFO
// boundary cases. A queue-based reference model checks random traffic on A.
module tb_ber_stream_monitor;

    localparam int CW = 32;

`ifdef BER_FIRST_ERR_CAPTURE_EN
    localparam bit CAPTURE = 1'b1;
`else
    localparam bit CAPTURE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A signals
    logic          a_reset, a_start, a_tx_data, a_tx_valid, a_rx_data, a_rx_valid, a_chan;
    logic [CW-1:0] a_tx_count, a_rx_count, a_chan_count, a_bit_err, a_first_idx;
    logic          a_busy, a_done, a_pass, a_fault, a_first_valid;

    // Instance B signals
    logic          b_reset, b_start, b_tx_valid, b_rx_valid, b_chan;
    logic [3:0]    b_tx_data, b_rx_data;
    logic [CW-1:0] b_tx_count, b_rx_count, b_chan_count, b_bit_err, b_first_idx;
    logic          b_busy, b_done, b_pass, b_fault, b_first_valid;

    ber_stream_monitor #(
        .DATA_W(1), .DEPTH(64), .CNT_W(CW), .FRAME_WORDS(200), .ERR_LIMIT(2)
    ) u_a (
        .clk(clk), .reset(a_reset), .start(a_start),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .chan_err_valid(a_chan),
        .tx_count(a_tx_count), .rx_count(a_rx_count),
        .chan_err_count(a_chan_count), .bit_err_count(a_bit_err),
        .busy(a_busy), .done(a_done), .pass(a_pass), .fault(a_fault),
        .first_err_idx(a_first_idx), .first_err_valid(a_first_valid)
    );

    ber_stream_monitor #(
        .DATA_W(4), .DEPTH(4), .CNT_W(CW), .FRAME_WORDS(8), .ERR_LIMIT(2)
    ) u_b (
        .clk(clk), .reset(b_reset), .start(b_start),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .chan_err_valid(b_chan),
        .tx_count(b_tx_count), .rx_count(b_rx_count),
        .chan_err_count(b_chan_count), .bit_err_count(b_bit_err),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fault(b_fault),
        .first_err_idx(b_first_idx), .first_err_valid(b_first_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input bit st, input bit tv, input bit td,
                           input bit rv, input bit rd, input bit ch);
        a_start = st; a_tx_valid = tv; a_tx_data = td;
        a_rx_valid = rv; a_rx_data = rd; a_chan = ch;
        tick();
    endtask

    task automatic b_drive(input bit st, input bit tv, input logic [3:0] td,
                           input bit rv, input logic [3:0] rd, input bit ch);
        b_start = st; b_tx_valid = tv; b_tx_data = td;
        b_rx_valid = rv; b_rx_data = rd; b_chan = ch;
        tick();
    endtask

    // One frame on A: TX every cycle, RX lagging by 'lag', RX bits flipped at f0/f1/f2.
    task automatic a_frame(input int lag, input int f0, input int f1, input int f2,
                           output int tx_sent, output int rx_sent);
        bit bits[$];
        bit tbit, rv, rd;
        a_drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_sent = 0;
        rx_sent = 0;
        for (int c = 0; c < 400 && !a_done; c++) begin
            tbit = 1'($urandom);
            bits.push_back(tbit);
            rv = (c >= lag);
            rd = 1'b0;
            if (rv) rd = bits[rx_sent] ^ ((rx_sent == f0) || (rx_sent == f1) || (rx_sent == f2));
            a_drive(1'b0, 1'b1, tbit, rv, rd, 1'b0);
            tx_sent++;
            if (rv) rx_sent++;
        end
    endtask

    // One frame on B with RX lagging by 2 and RX word 5 XORed with 'mask'.
    task automatic b_frame(input logic [3:0] mask, output int rx_sent);
        logic [3:0] words[$];
        logic [3:0] w, rd;
        bit rv;
        b_drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        rx_sent = 0;
        for (int c = 0; c < 40 && !b_done; c++) begin
            w = 4'($urandom);
            words.push_back(w);
            rv = (c >= 2);
            rd = 4'h0;
            if (rv) rd = words[rx_sent] ^ ((rx_sent == 5) ? mask : 4'h0);
            b_drive(1'b0, 1'b1, w, rv, rd, 1'b0);
            if (rv) rx_sent++;
        end
    endtask

    // Reference model for instance A: a queue of outstanding TX bits plus counts.
    typedef enum {M_IDLE, M_RUN, M_DONE, M_FAULT} mstate_t;
    mstate_t m_state;
    bit      mq[$];
    longint  m_tx, m_rx, m_ch, m_err, m_fidx;
    bit      m_fval;

    task automatic model_clear();
        mq.delete();
        m_tx = 0; m_rx = 0; m_ch = 0; m_err = 0; m_fidx = 0; m_fval = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit tv, input bit td,
                              input bit rv, input bit rd, input bit ch);
        bit r;
        if (m_state == M_RUN) begin
            if ((tv && !rv && mq.size() == 64) || (rv && !tv && mq.size() == 0)) begin
                m_state = M_FAULT;
            end else begin
                if (tv) begin
                    mq.push_back(td);
                    m_tx++;
                end
                if (ch) m_ch++;
                if (rv) begin
                    r = mq.pop_front();
                    if (r != rd) begin
                        if (!m_fval) begin
                            m_fval = 1'b1;
                            m_fidx = m_rx;
                        end
                        m_err++;
                    end
                    m_rx++;
                    if (m_rx == 200) m_state = M_DONE;
                end
            end
        end else if (st) begin
            model_clear();
            m_state = M_RUN;
        end
    endtask

    task automatic run_random();
        int p_tx, p_rx;
        bit st, tv, td, rv, rd, ch, ref_bit;
        a_reset = 1'b1;
        a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        a_reset = 1'b0;
        m_state = M_IDLE;
        model_clear();
        for (int run = 0; run < 12; run++) begin
            p_tx = $urandom_range(30, 100);
            p_rx = $urandom_range(30, 100);
            for (int c = 0; c < 350; c++) begin
                st = (c == 0) || ($urandom_range(0, 199) == 0);
                tv = ($urandom_range(1, 100) <= p_tx);
                td = 1'($urandom);
                rv = ($urandom_range(1, 100) <= p_rx);
                ch = ($urandom_range(0, 7) == 0);
                ref_bit = (mq.size() > 0) ? mq[0] : td;
                rd = ref_bit ^ ($urandom_range(0, 31) == 0);
                a_drive(st, tv, td, rv, rd, ch);
                model_step(st, tv, td, rv, rd, ch);
                check("rnd_tx_count", a_tx_count, m_tx);
                check("rnd_rx_count", a_rx_count, m_rx);
                check("rnd_chan_count", a_chan_count, m_ch);
                check("rnd_bit_err", a_bit_err, m_err);
                check("rnd_flags", {a_busy, a_done, a_fault, a_pass},
                      {m_state == M_RUN, m_state == M_DONE, m_state == M_FAULT,
                       (m_state == M_DONE) && (m_err <= 2)});
                check("rnd_first_err", {a_first_valid, a_first_idx},
                      {CAPTURE & m_fval, CAPTURE ? 32'(m_fidx) : 32'd0});
            end
        end
    endtask

    typedef struct {
        bit         tv;
        logic [3:0] td;
        bit         rv;
        logic [3:0] rd;
        bit         ch;
        int         e_tx, e_rx, e_ch, e_err;
        bit         e_busy, e_fault;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int tx_sent, rx_sent;
        logic [3:0] fq[$];
        logic [3:0] w;

        // Table for B after a START: FIFO, bypass, underflow and post-fault behaviour.
        vecs[0]  = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1, 0, 0, 0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'h5, 1'b1, 4'hA, 1'b1, 2, 1, 1, 0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 2, 2, 1, 1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 3, 3, 1, 5, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 3, 3, 2, 5, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 4, 3, 2, 5, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'hC, 1'b1, 4'h3, 1'b0, 5, 4, 2, 5, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'h6, 1'b0, 4'h0, 1'b0, 6, 4, 2, 5, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 1'b1, 4'hC, 1'b0, 6, 5, 2, 5, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 1'b1, 4'h7, 1'b0, 6, 6, 2, 6, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 6, 6, 2, 6, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 6, 6, 2, 6, 1'b0, 1'b1};

        a_reset = 1'b1; a_start = 1'b0; a_tx_data = 1'b0; a_tx_valid = 1'b0;
        a_rx_data = 1'b0; a_rx_valid = 1'b0; a_chan = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_tx_data = 4'h0; b_tx_valid = 1'b0;
        b_rx_data = 4'h0; b_rx_valid = 1'b0; b_chan = 1'b0;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state
        check("a_reset_counts", {a_tx_count, a_rx_count}, 64'd0);
        check("a_reset_errs", {a_chan_count, a_bit_err}, 64'd0);
        check("a_reset_flags", {a_busy, a_done, a_pass, a_fault, a_first_valid}, 5'b0);
        check("b_reset_counts", {b_tx_count, b_rx_count}, 64'd0);
        check("b_reset_flags", {b_busy, b_done, b_pass, b_fault, b_first_valid}, 5'b0);

        // Clean frame, RX lagging 7 cycles
        a_frame(7, -1, -1, -1, tx_sent, rx_sent);
        check("clean_done", a_done, 1'b1);
        check("clean_pass", a_pass, 1'b1);
        check("clean_bit_err", a_bit_err, 0);
        check("clean_rx_count", a_rx_count, 200);
        check("clean_rx_presented", rx_sent, 200);
        check("clean_tx_count", a_tx_count, tx_sent);
        check("clean_busy", a_busy, 1'b0);

        // Inputs after DONE are ignored
        a_drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("done_hold_rx", a_rx_count, 200);
        check("done_hold_chan", a_chan_count, 0);
        check("done_hold_flag", a_done, 1'b1);

        // START in DONE clears and restarts; inputs in the START cycle ignored
        a_drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("restart_counts", {a_tx_count, a_rx_count, a_chan_count, a_bit_err}, 128'd0);
        check("restart_flags", {a_busy, a_done, a_pass, a_fault}, 4'b1000);

        // Three flipped bits exceed ERR_LIMIT
        a_frame(7, 10, 50, 120, tx_sent, rx_sent);
        check("flip_done", a_done, 1'b1);
        check("flip_bit_err", a_bit_err, 3);
        check("flip_pass", a_pass, 1'b0);
        check("flip_rx_count", a_rx_count, 200);
        check("flip_first_idx", a_first_idx, CAPTURE ? 10 : 0);
        check("flip_first_valid", a_first_valid, CAPTURE);

        // START in RUN is ignored; channel strobes counted independently
        a_drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) a_drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        a_drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_in_run_tx", a_tx_count, 5);
        check("start_in_run_busy", a_busy, 1'b1);
        a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        a_drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        a_drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("chan_count", a_chan_count, 3);
        check("chan_tx_count", a_tx_count, 7);
        check("chan_rx_count", a_rx_count, 1);

        // Reset mid-RUN at RX_COUNT=37
        for (int i = 0; i < 100 && a_rx_count != 37; i++)
            a_drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("pre_reset_rx", a_rx_count, 37);
        a_reset = 1'b1;
        a_drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        a_reset = 1'b0;
        check("midreset_counts", {a_tx_count, a_rx_count, a_chan_count, a_bit_err}, 128'd0);
        check("midreset_flags", {a_busy, a_done, a_pass, a_fault, a_first_valid, a_first_idx}, 37'd0);
        a_drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("idle_ignores_inputs", {a_tx_count, a_chan_count, a_busy}, 65'd0);

        // Empty FIFO with simultaneous TX/RX: bypass, FIFO stays empty
        a_drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            w[0] = 1'($urandom);
            a_drive(1'b0, 1'b1, w[0], 1'b1, w[0], 1'b0);
        end
        check("bypass_rx_count", a_rx_count, 20);
        check("bypass_tx_count", a_tx_count, 20);
        check("bypass_bit_err", a_bit_err, 0);
        check("bypass_no_fault", {a_busy, a_fault}, 2'b10);
        a_drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bypass_then_underflow", a_fault, 1'b1);
        check("bypass_underflow_rx", a_rx_count, 20);

        // Random traffic against the reference model
        run_random();

        // Table-driven sequence on B
        b_drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            b_drive(1'b0, vecs[i].tv, vecs[i].td, vecs[i].rv, vecs[i].rd, vecs[i].ch);
            check($sformatf("vec%0d_tx", i), b_tx_count, vecs[i].e_tx);
            check($sformatf("vec%0d_rx", i), b_rx_count, vecs[i].e_rx);
            check($sformatf("vec%0d_chan", i), b_chan_count, vecs[i].e_ch);
            check($sformatf("vec%0d_bit_err", i), b_bit_err, vecs[i].e_err);
            check($sformatf("vec%0d_flags", i), {b_busy, b_fault}, {vecs[i].e_busy, vecs[i].e_fault});
        end

        // 4-bit words: word 5 XOR 1011 fails, XOR 0001 passes
        b_frame(4'b1011, rx_sent);
        check("w4_1011_done", b_done, 1'b1);
        check("w4_1011_bit_err", b_bit_err, 3);
        check("w4_1011_pass", b_pass, 1'b0);
        check("w4_1011_first", {b_first_valid, b_first_idx}, {CAPTURE, CAPTURE ? 32'd5 : 32'd0});
        b_frame(4'b0001, rx_sent);
        check("w4_0001_done", b_done, 1'b1);
        check("w4_0001_bit_err", b_bit_err, 1);
        check("w4_0001_pass", b_pass, 1'b1);
        check("w4_0001_rx", b_rx_count, 8);

        // Overflow: fifth push into a 4-deep FIFO
        b_drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) b_drive(1'b0, 1'b1, 4'(i), 1'b0, 4'h0, 1'b0);
        check("ovf_pre_tx", b_tx_count, 4);
        check("ovf_pre_fault", b_fault, 1'b0);
        b_drive(1'b0, 1'b1, 4'h9, 1'b0, 4'h0, 1'b0);
        check("ovf_fault", b_fault, 1'b1);
        check("ovf_tx_frozen", b_tx_count, 4);
        check("ovf_busy", b_busy, 1'b0);

        // Underflow in a fresh run
        b_drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        b_drive(1'b0, 1'b0, 4'h0, 1'b1, 4'h3, 1'b0);
        check("udf_fault", b_fault, 1'b1);
        check("udf_rx", b_rx_count, 0);

        // Full FIFO with simultaneous push/pop
        b_drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = 4'($urandom);
            fq.push_back(w);
            b_drive(1'b0, 1'b1, w, 1'b0, 4'h0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            w = 4'($urandom);
            fq.push_back(w);
            b_drive(1'b0, 1'b1, w, 1'b1, fq.pop_front(), 1'b0);
        end
        check("full_both_fault", {b_busy, b_fault}, 2'b10);
        check("full_both_rx", b_rx_count, 6);
        check("full_both_tx", b_tx_count, 10);
        check("full_both_bit_err", b_bit_err, 0);
        b_drive(1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0);
        check("full_then_overflow", b_fault, 1'b1);
        check("full_overflow_tx", b_tx_count, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no summary by time limit, expected bench to finish");
        $fatal(1, "time limit");
    end

endmodule
